// File: rtl/data_memory_ctrl_if.sv
// Load/store bus for data_memory_ctrl: request/ready/valid handshake plus
// address, store data, byte mask, read data and out-of-range flag.
interface data_memory_ctrl_if #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ADDR_WIDTH = 16
);
  logic                    request;
  logic                    load;
  logic [ADDR_WIDTH-1:0]   address;
  logic [DATA_WIDTH-1:0]   write_data;
  logic [DATA_WIDTH/8-1:0] byte_enable;
  logic                    ready;
  logic                    valid;
  logic [DATA_WIDTH-1:0]   output_data;
  logic                    error;

  modport master (
    output request, load, address, write_data, byte_enable,
    input  ready, valid, output_data, error
  );

  modport slave (
    input  request, load, address, write_data, byte_enable,
    output ready, valid, output_data, error
  );
endinterface

// File: rtl/data_memory_ctrl.sv
// Clocked single-port data memory with byte-enable writes, registered reads and
// a post-reset zero sweep. Define DATA_MEMORY_CTRL_BOUNDS_EN for range checking.
module data_memory_ctrl #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned DEPTH      = 256
) (
  input logic               clk,
  input logic               reset_n,
  data_memory_ctrl_if.slave bus
);
  localparam int unsigned IDX_W  = $clog2(DEPTH);
  localparam int unsigned NBYTES = DATA_WIDTH / 8;

  typedef enum logic {INIT, IDLE} state_e;

  state_e                  state_q, state_d;
  logic [IDX_W-1:0]        cnt_q, cnt_d;
  logic                    ready_q, ready_d;
  logic                    valid_q, valid_d;
  logic                    error_q, error_d;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;

  logic [DATA_WIDTH-1:0]   mem [DEPTH];

  logic                    accept;
  logic                    oob;
  logic [IDX_W-1:0]        idx;
  logic                    mem_we;
  logic [NBYTES-1:0]       mem_be;
  logic [IDX_W-1:0]        mem_idx;
  logic [DATA_WIDTH-1:0]   mem_wdata;

  always_comb begin
    idx = bus.address[IDX_W-1:0];
`ifdef DATA_MEMORY_CTRL_BOUNDS_EN
    oob = (bus.address >> IDX_W) != '0;
`else
    oob = 1'b0;
`endif
    // ready_q is only ever set in IDLE, so it alone qualifies an accept
    accept    = ready_q & bus.request;

    state_d   = state_q;
    cnt_d     = cnt_q;
    ready_d   = ready_q;
    valid_d   = accept;
    error_d   = accept & oob;
    rdata_d   = rdata_q;
    mem_we    = 1'b0;
    mem_be    = '0;
    mem_idx   = idx;
    mem_wdata = bus.write_data;

    case (state_q)
      INIT: begin
        mem_we    = 1'b1;
        mem_be    = '1;
        mem_idx   = cnt_q;
        mem_wdata = '0;
        cnt_d     = cnt_q + 1'b1;
        if (cnt_q == IDX_W'(DEPTH - 1)) begin
          state_d = IDLE;
          ready_d = 1'b1;
        end
      end
      IDLE: begin
        if (accept) begin
          if (bus.load) begin
            mem_we = ~oob;
            mem_be = bus.byte_enable;
          end else begin
            rdata_d = oob ? '0 : mem[idx];
          end
        end
      end
      default: begin
        state_d = INIT;
        ready_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= INIT;
      cnt_q   <= '0;
      ready_q <= 1'b0;
      valid_q <= 1'b0;
      error_q <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
      valid_q <= valid_d;
      error_q <= error_d;
      rdata_q <= rdata_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int unsigned b = 0; b < NBYTES; b++) begin
        if (mem_be[b]) mem[mem_idx][8*b +: 8] <= mem_wdata[8*b +: 8];
      end
    end
  end

  assign bus.ready       = ready_q;
  assign bus.valid       = valid_q;
  assign bus.error       = error_q;
  assign bus.output_data = rdata_q;
endmodule

// File: tb/tb_data_memory_ctrl.sv
// Directed plus randomized bench for data_memory_ctrl, checked against an
// array-based memory model.
module tb_data_memory_ctrl;
  localparam int unsigned DW    = 16;
  localparam int unsigned AW    = 16;
  localparam int unsigned DEPTH = 256;
`ifdef DATA_MEMORY_CTRL_BOUNDS_EN
  localparam bit BOUNDS = 1'b1;
`else
  localparam bit BOUNDS = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  data_memory_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  data_memory_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  logic [DW-1:0] model_mem [DEPTH];
  logic [DW-1:0] last_rd;
  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < int'(DEPTH); i++) model_mem[i] = '0;
    last_rd = '0;
  endtask

  // Release reset, hold a request during the sweep, and count edges until ready.
  task automatic release_and_wait();
    int n;
    @(negedge clk);
    bus.request = 1'b1;
    bus.load    = 1'b0;
    bus.address = 16'd5;
    reset_n     = 1'b1;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!bus.ready && n < 1000);
    check("ready_latency", 64'(n), 64'(DEPTH));
    check("no_valid_in_init", 64'(bus.valid), 64'd0);
    model_clear();
  endtask

  task automatic access(input logic ld, input logic [AW-1:0] a,
                        input logic [DW-1:0] wd, input logic [1:0] be);
    int unsigned idx;
    bit oob;
    logic [DW-1:0] exp;
    @(negedge clk);
    bus.request     = 1'b1;
    bus.load        = ld;
    bus.address     = a;
    bus.write_data  = wd;
    bus.byte_enable = be;
    @(posedge clk); #1;
    oob = BOUNDS && (int'(a) >= int'(DEPTH));
    idx = int'(a) % DEPTH;
    if (ld) begin
      if (!oob)
        for (int b = 0; b < 2; b++)
          if (be[b]) model_mem[idx][8*b +: 8] = wd[8*b +: 8];
      exp = last_rd;
    end else begin
      exp = oob ? '0 : model_mem[idx];
      last_rd = exp;
    end
    check(ld ? "wr_valid" : "rd_valid", 64'(bus.valid), 64'd1);
    check(ld ? "wr_data_hold" : "rd_data", 64'(bus.output_data), 64'(exp));
    check(ld ? "wr_error" : "rd_error", 64'(bus.error), 64'(oob));
  endtask

  task automatic idle();
    @(negedge clk);
    bus.request = 1'b0;
    @(posedge clk); #1;
    check("idle_valid", 64'(bus.valid), 64'd0);
    check("idle_data_hold", 64'(bus.output_data), 64'(last_rd));
  endtask

  initial begin
    bus.request     = 1'b0;
    bus.load        = 1'b0;
    bus.address     = '0;
    bus.write_data  = '0;
    bus.byte_enable = '0;
    #12;
    check("rst_ready", 64'(bus.ready), 64'd0);
    check("rst_valid", 64'(bus.valid), 64'd0);
    check("rst_data", 64'(bus.output_data), 64'd0);
    check("rst_error", 64'(bus.error), 64'd0);

    // 1: sweep then read zeroed word
    release_and_wait();
    idle();
    access(1'b0, 16'd5, '0, 2'b00);
    idle();

    // 2, 3: full and partial byte writes
    access(1'b1, 16'd0, 16'hAABB, 2'b11);
    access(1'b0, 16'd0, '0, 2'b00);
    access(1'b1, 16'd0, 16'hFFFF, 2'b01);
    access(1'b0, 16'd0, '0, 2'b00);
    access(1'b1, 16'd0, 16'h1111, 2'b00);
    access(1'b0, 16'd0, '0, 2'b00);
    check("partial_literal", 64'(last_rd), 64'h0000_AAFF);
    idle();

    // 4: back-to-back write then read of the same address
    access(1'b1, 16'd1, 16'hFFFF, 2'b11);
    access(1'b0, 16'd1, '0, 2'b00);
    check("b2b_literal", 64'(last_rd), 64'h0000_FFFF);
    idle();

    // 5: reset asserted mid-read
    access(1'b1, 16'd2, 16'h1234, 2'b11);
    access(1'b0, 16'd2, '0, 2'b00);
    reset_n = 1'b0;
    bus.request = 1'b0;
    #1;
    check("midrst_valid", 64'(bus.valid), 64'd0);
    check("midrst_ready", 64'(bus.ready), 64'd0);
    check("midrst_data", 64'(bus.output_data), 64'd0);
    @(posedge clk);
    release_and_wait();
    idle();
    access(1'b0, 16'd2, '0, 2'b00);
    access(1'b0, 16'd0, '0, 2'b00);
    idle();

    // 6: address beyond DEPTH
    access(1'b1, 16'd256, 16'hBEEF, 2'b11);
    access(1'b0, 16'd0, '0, 2'b00);
    access(1'b0, 16'd256, '0, 2'b00);
    idle();

    // Randomized traffic, mostly in range
    for (int i = 0; i < 300; i++) begin
      logic [AW-1:0] a;
      int unsigned r;
      r = $urandom_range(0, 9);
      a = (r == 0) ? AW'($urandom_range(DEPTH, 4*DEPTH - 1))
                   : AW'($urandom_range(0, 15));
      if (r == 9) idle();
      else access(1'($urandom_range(0, 1)), a, DW'($urandom), 2'($urandom_range(0, 3)));
    end
    idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
